// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - SDRAM command encodings and read-latency helper
package sdram_pkg;

    // {ras_n, cas_n, we_n} command encodings
    localparam logic [2:0] CMD_NOP       = 3'b111;
    localparam logic [2:0] CMD_ACTIVE    = 3'b011;
    localparam logic [2:0] CMD_READ      = 3'b101;
    localparam logic [2:0] CMD_WRITE     = 3'b100;
    localparam logic [2:0] CMD_PRECHARGE = 3'b010;
    localparam logic [2:0] CMD_REFRESH   = 3'b001;
    localparam logic [2:0] CMD_LOAD_MODE = 3'b000;

    // Cycles from rd_req to rd_valid: device CL, board round-trip,
    // the IOB input register and the fabric re-register.
    function automatic int rd_lat(input int cl, input int dly);
        return cl + dly + 2;
    endfunction

endpackage

// File: rtl/sdram_clk_fwd.sv
// rtl/sdram_clk_fwd.sv - ODDR-style forwarded SDRAM clock, 180 degrees from clk
module sdram_clk_fwd (
    input  logic clk,
    input  logic rst,
    output logic clk_out
);

    logic rise_q;
    logic fall_q;

    // Rising-edge half of the DDR output cell: D1 = 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q <= 1'b0;
        end else begin
            rise_q <= 1'b0;
        end
    end

    // Falling-edge half of the DDR output cell: D2 = 1, so the output is low in reset
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= 1'b1;
        end
    end

    // Output mux of the DDR cell: the clk-high half shows D1, the clk-low half shows D2
    assign clk_out = clk ? rise_q : fall_q;

endmodule

// File: rtl/sdram_phy.sv
// rtl/sdram_phy.sv - SDRAM pin-level PHY with read alignment and conflict detection
module sdram_phy
    import sdram_pkg::*;
#(
    parameter int DQ_WIDTH         = 16,
    parameter int ADDR_WIDTH       = 13,
    parameter int BA_WIDTH         = 2,
    parameter int CAS_LATENCY      = 2,
    parameter int RD_CAPTURE_DELAY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cke,
    input  logic                    cs_n,
    input  logic [2:0]              cmd,
    input  logic [BA_WIDTH-1:0]     ba,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DQ_WIDTH/8-1:0]   dqm,
    input  logic                    wr_en,
    input  logic [DQ_WIDTH-1:0]     wr_data,
    input  logic                    rd_req,
    input  logic                    clr_conflict,
    output logic                    rd_valid,
    output logic [DQ_WIDTH-1:0]     rd_data,
    output logic                    bus_conflict,
    output logic                    clk_sdram,
    output logic                    sdram_cke,
    output logic                    sdram_cs_n,
    output logic                    sdram_ras_n,
    output logic                    sdram_cas_n,
    output logic                    sdram_we_n,
    output logic [DQ_WIDTH/8-1:0]   sdram_dqm,
    output logic [BA_WIDTH-1:0]     sdram_ba,
    output logic [ADDR_WIDTH-1:0]   sdram_a,
    inout  wire  [DQ_WIDTH-1:0]     sdram_dq
);

    localparam int RD_LAT = rd_lat(CAS_LATENCY, RD_CAPTURE_DELAY);

    generate
        if (CAS_LATENCY != 2 && CAS_LATENCY != 3) begin : g_bad_cl
            $error("sdram_phy: CAS_LATENCY must be 2 or 3");
        end
        if (RD_CAPTURE_DELAY < 0 || RD_CAPTURE_DELAY > 3) begin : g_bad_dly
            $error("sdram_phy: RD_CAPTURE_DELAY must be 0..3");
        end
        if (DQ_WIDTH % 8 != 0) begin : g_bad_dq
            $error("sdram_phy: DQ_WIDTH must be a multiple of 8");
        end
    endgenerate

    logic [RD_LAT-1:0]   rd_pipe;
    logic [DQ_WIDTH-1:0] dq_out;
    logic [DQ_WIDTH-1:0] dq_oe;
    logic [DQ_WIDTH-1:0] dq_in_q;
    logic                read_on_bus;
    logic                wr_conflict;
    logic                wr_go;

    // A read occupies the bus from the request until the device has finished
    // driving DQ, so a write launched inside that window would collide with it.
    always_comb begin
        read_on_bus = rd_req | (|rd_pipe[CAS_LATENCY:0]);
        wr_conflict = wr_en & read_on_bus;
        wr_go       = wr_en & ~read_on_bus;
    end

    // Command/address IOB registers; a colliding write beat is masked off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdram_cke   <= 1'b0;
            sdram_cs_n  <= 1'b1;
            {sdram_ras_n, sdram_cas_n, sdram_we_n} <= CMD_NOP;
            sdram_dqm   <= '1;
            sdram_ba    <= '0;
            sdram_a     <= '0;
        end else begin
            sdram_cke   <= cke;
            sdram_cs_n  <= cs_n;
            {sdram_ras_n, sdram_cas_n, sdram_we_n} <= cmd;
            sdram_dqm   <= wr_conflict ? '1 : dqm;
            sdram_ba    <= ba;
            sdram_a     <= addr;
        end
    end

    // Write data and per-bit output-enable IOB registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq_out <= '0;
            dq_oe  <= '0;
        end else begin
            dq_out <= wr_data;
            dq_oe  <= {DQ_WIDTH{wr_go}};
        end
    end

    // DQ tristate driven straight from the output/enable registers
    genvar gi;
    generate
        for (gi = 0; gi < DQ_WIDTH; gi++) begin : g_dq
            assign sdram_dq[gi] = dq_oe[gi] ? dq_out[gi] : 1'bz;
        end
    endgenerate

    // Read-valid shift register; one stage per cycle of read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe <= {rd_pipe[RD_LAT-2:0], rd_req};
        end
    end

    // IOB input capture, then fabric re-register when the matching beat arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq_in_q <= '0;
            rd_data <= '0;
        end else begin
            dq_in_q <= sdram_dq;
            if (rd_pipe[RD_LAT-2]) begin
                rd_data <= dq_in_q;
            end
        end
    end

    assign rd_valid = rd_pipe[RD_LAT-1];

    // Sticky conflict flag; a new conflict outranks a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_conflict <= 1'b0;
        end else if (wr_conflict) begin
            bus_conflict <= 1'b1;
        end else if (clr_conflict) begin
            bus_conflict <= 1'b0;
        end
    end

    sdram_clk_fwd u_clk_fwd (
        .clk     (clk),
        .rst     (rst),
        .clk_out (clk_sdram)
    );

endmodule
